// File: rtl/ddr4_axi_arbiter_2to1.sv
// Two-master to one-slave AXI4 arbiter in front of the DDR4 controller port.
// s0 = simulator host-memory master, s1 = PCIe bulk-DMA master.
// Independent round-robin arbitration on AW and AR. The master index is
// carried in the ID MSB so that B and R responses can be steered back
// without any lookup state.
module ddr4_axi_arbiter_2to1 #(
  parameter int unsigned ADDR_W = 34,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ID_W   = 16
) (
  input  logic                  sys_clk,
  input  logic                  sys_reset_n,
  // master 0
  input  logic                  s0_awvalid,
  output logic                  s0_awready,
  input  logic [ADDR_W-1:0]     s0_awaddr,
  input  logic [7:0]            s0_awlen,
  input  logic [2:0]            s0_awsize,
  input  logic [ID_W-2:0]       s0_awid,
  input  logic                  s0_wvalid,
  output logic                  s0_wready,
  input  logic                  s0_wlast,
  input  logic [DATA_W-1:0]     s0_wdata,
  input  logic [DATA_W/8-1:0]   s0_wstrb,
  output logic                  s0_bvalid,
  input  logic                  s0_bready,
  output logic [1:0]            s0_bresp,
  output logic [ID_W-2:0]       s0_bid,
  input  logic                  s0_arvalid,
  output logic                  s0_arready,
  input  logic [ADDR_W-1:0]     s0_araddr,
  input  logic [7:0]            s0_arlen,
  input  logic [2:0]            s0_arsize,
  input  logic [ID_W-2:0]       s0_arid,
  output logic                  s0_rvalid,
  input  logic                  s0_rready,
  output logic                  s0_rlast,
  output logic [1:0]            s0_rresp,
  output logic [DATA_W-1:0]     s0_rdata,
  output logic [ID_W-2:0]       s0_rid,
  // master 1
  input  logic                  s1_awvalid,
  output logic                  s1_awready,
  input  logic [ADDR_W-1:0]     s1_awaddr,
  input  logic [7:0]            s1_awlen,
  input  logic [2:0]            s1_awsize,
  input  logic [ID_W-2:0]       s1_awid,
  input  logic                  s1_wvalid,
  output logic                  s1_wready,
  input  logic                  s1_wlast,
  input  logic [DATA_W-1:0]     s1_wdata,
  input  logic [DATA_W/8-1:0]   s1_wstrb,
  output logic                  s1_bvalid,
  input  logic                  s1_bready,
  output logic [1:0]            s1_bresp,
  output logic [ID_W-2:0]       s1_bid,
  input  logic                  s1_arvalid,
  output logic                  s1_arready,
  input  logic [ADDR_W-1:0]     s1_araddr,
  input  logic [7:0]            s1_arlen,
  input  logic [2:0]            s1_arsize,
  input  logic [ID_W-2:0]       s1_arid,
  output logic                  s1_rvalid,
  input  logic                  s1_rready,
  output logic                  s1_rlast,
  output logic [1:0]            s1_rresp,
  output logic [DATA_W-1:0]     s1_rdata,
  output logic [ID_W-2:0]       s1_rid,
  // DDR4 slave port
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [ADDR_W-1:0]     m_awaddr,
  output logic [7:0]            m_awlen,
  output logic [2:0]            m_awsize,
  output logic [ID_W-1:0]       m_awid,
  output logic [1:0]            m_awburst,
  output logic                  m_awlock,
  output logic [3:0]            m_awcache,
  output logic [2:0]            m_awprot,
  output logic [3:0]            m_awqos,
  output logic [3:0]            m_awregion,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  output logic                  m_wlast,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  input  logic [1:0]            m_bresp,
  input  logic [ID_W-1:0]       m_bid,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  output logic [ADDR_W-1:0]     m_araddr,
  output logic [7:0]            m_arlen,
  output logic [2:0]            m_arsize,
  output logic [ID_W-1:0]       m_arid,
  output logic [1:0]            m_arburst,
  output logic                  m_arlock,
  output logic [3:0]            m_arcache,
  output logic [2:0]            m_arprot,
  output logic [3:0]            m_arqos,
  output logic [3:0]            m_arregion,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  input  logic                  m_rlast,
  input  logic [1:0]            m_rresp,
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic [ID_W-1:0]       m_rid
);

  typedef enum logic {W_IDLE = 1'b0, W_BUSY = 1'b1} w_state_t;
  typedef enum logic {R_IDLE = 1'b0, R_ISSUE = 1'b1} r_state_t;

  w_state_t w_state, w_state_nxt;
  r_state_t r_state, r_state_nxt;

  logic act_q;
  logic aw_ptr, aw_sel, aw_win, aw_grant, w_done;
  logic sel_wvalid, sel_wlast, w_open, wlast_hs;
  logic ar_ptr, ar_win, ar_grant;

  // Fixed attributes toward the controller: INCR bursts, everything else neutral.
  assign m_awburst  = 2'b01;
  assign m_awlock   = 1'b0;
  assign m_awcache  = 4'd0;
  assign m_awprot   = 3'd0;
  assign m_awqos    = 4'd0;
  assign m_awregion = 4'd0;
  assign m_arburst  = 2'b01;
  assign m_arlock   = 1'b0;
  assign m_arcache  = 4'd0;
  assign m_arprot   = 3'd0;
  assign m_arqos    = 4'd0;
  assign m_arregion = 4'd0;

  // Grants are held off until the first clock after reset release.
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) act_q <= 1'b0;
    else              act_q <= 1'b1;
  end

  // ---------------- write path ----------------

  // AW round-robin decision and write-burst progress.
  always_comb begin
    aw_win     = (s0_awvalid && s1_awvalid) ? aw_ptr : s1_awvalid;
    aw_grant   = act_q && (w_state == W_IDLE) && (s0_awvalid || s1_awvalid);
    sel_wvalid = aw_sel ? s1_wvalid : s0_wvalid;
    sel_wlast  = aw_sel ? s1_wlast  : s0_wlast;
    w_open     = (w_state == W_BUSY) && !w_done;
    wlast_hs   = w_open && sel_wvalid && m_wready && sel_wlast;
  end

  // Write FSM state register.
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) w_state <= W_IDLE;
    else              w_state <= w_state_nxt;
  end

  // Write FSM next state: busy until both the AW and the last W beat are accepted.
  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE: if (aw_grant) w_state_nxt = W_BUSY;
      W_BUSY: if ((!m_awvalid || m_awready) && (w_done || wlast_hs)) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Write FSM outputs: AW ready pulse and W pass-through from the granted master.
  always_comb begin
    s0_awready = aw_grant && !aw_win;
    s1_awready = aw_grant &&  aw_win;
    m_wvalid   = w_open && sel_wvalid;
    m_wlast    = sel_wlast;
    m_wdata    = aw_sel ? s1_wdata : s0_wdata;
    m_wstrb    = aw_sel ? s1_wstrb : s0_wstrb;
    s0_wready  = w_open && !aw_sel && m_wready;
    s1_wready  = w_open &&  aw_sel && m_wready;
  end

  // AW payload capture, RR pointer and burst bookkeeping.
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      aw_ptr    <= 1'b0;
      aw_sel    <= 1'b0;
      w_done    <= 1'b0;
      m_awvalid <= 1'b0;
      m_awaddr  <= '0;
      m_awlen   <= '0;
      m_awsize  <= '0;
      m_awid    <= '0;
    end else if (aw_grant) begin
      aw_ptr    <= !aw_win;
      aw_sel    <= aw_win;
      w_done    <= 1'b0;
      m_awvalid <= 1'b1;
      m_awaddr  <= aw_win ? s1_awaddr : s0_awaddr;
      m_awlen   <= aw_win ? s1_awlen  : s0_awlen;
      m_awsize  <= aw_win ? s1_awsize : s0_awsize;
      m_awid    <= {aw_win, (aw_win ? s1_awid : s0_awid)};
    end else begin
      if (m_awvalid && m_awready) m_awvalid <= 1'b0;
      if (wlast_hs)               w_done    <= 1'b1;
    end
  end

  // ---------------- read path ----------------

  // AR round-robin decision.
  always_comb begin
    ar_win   = (s0_arvalid && s1_arvalid) ? ar_ptr : s1_arvalid;
    ar_grant = act_q && (r_state == R_IDLE) && (s0_arvalid || s1_arvalid);
  end

  // Read FSM state register.
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) r_state <= R_IDLE;
    else              r_state <= r_state_nxt;
  end

  // Read FSM next state: one AR in the issue stage at a time.
  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_grant)  r_state_nxt = R_ISSUE;
      R_ISSUE: if (m_arready) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Read FSM outputs: AR ready pulse to the winner.
  always_comb begin
    s0_arready = ar_grant && !ar_win;
    s1_arready = ar_grant &&  ar_win;
  end

  // AR payload capture and RR pointer.
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      ar_ptr    <= 1'b0;
      m_arvalid <= 1'b0;
      m_araddr  <= '0;
      m_arlen   <= '0;
      m_arsize  <= '0;
      m_arid    <= '0;
    end else if (ar_grant) begin
      ar_ptr    <= !ar_win;
      m_arvalid <= 1'b1;
      m_araddr  <= ar_win ? s1_araddr : s0_araddr;
      m_arlen   <= ar_win ? s1_arlen  : s0_arlen;
      m_arsize  <= ar_win ? s1_arsize : s0_arsize;
      m_arid    <= {ar_win, (ar_win ? s1_arid : s0_arid)};
    end else if (m_arvalid && m_arready) begin
      m_arvalid <= 1'b0;
    end
  end

  // ---------------- responses ----------------

  // B and R steered by the ID MSB; payload fans out, only valid is gated.
  always_comb begin
    s0_bvalid = m_bvalid && !m_bid[ID_W-1];
    s1_bvalid = m_bvalid &&  m_bid[ID_W-1];
    s0_bid    = m_bid[ID_W-2:0];
    s1_bid    = m_bid[ID_W-2:0];
    s0_bresp  = m_bresp;
    s1_bresp  = m_bresp;
    m_bready  = m_bid[ID_W-1] ? s1_bready : s0_bready;

    s0_rvalid = m_rvalid && !m_rid[ID_W-1];
    s1_rvalid = m_rvalid &&  m_rid[ID_W-1];
    s0_rid    = m_rid[ID_W-2:0];
    s1_rid    = m_rid[ID_W-2:0];
    s0_rdata  = m_rdata;
    s1_rdata  = m_rdata;
    s0_rresp  = m_rresp;
    s1_rresp  = m_rresp;
    s0_rlast  = m_rlast;
    s1_rlast  = m_rlast;
    m_rready  = m_rid[ID_W-1] ? s1_rready : s0_rready;
  end

endmodule

// File: tb/tb_ddr4_axi_arbiter_2to1.sv
// Bench for ddr4_axi_arbiter_2to1: directed scenarios plus randomized AR
// traffic and response routing, checked against a small reference model.
module tb_ddr4_axi_arbiter_2to1;

  localparam int unsigned ADDR_W = 34;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned ID_W   = 16;
  localparam int unsigned STRB_W = DATA_W / 8;

  logic sys_clk, sys_reset_n;
  logic s0_awvalid, s0_awready, s0_wvalid, s0_wready, s0_wlast, s0_bvalid, s0_bready;
  logic s0_arvalid, s0_arready, s0_rvalid, s0_rready, s0_rlast;
  logic [ADDR_W-1:0] s0_awaddr, s0_araddr;
  logic [7:0] s0_awlen, s0_arlen;
  logic [2:0] s0_awsize, s0_arsize;
  logic [ID_W-2:0] s0_awid, s0_arid, s0_bid, s0_rid;
  logic [DATA_W-1:0] s0_wdata, s0_rdata;
  logic [STRB_W-1:0] s0_wstrb;
  logic [1:0] s0_bresp, s0_rresp;
  logic s1_awvalid, s1_awready, s1_wvalid, s1_wready, s1_wlast, s1_bvalid, s1_bready;
  logic s1_arvalid, s1_arready, s1_rvalid, s1_rready, s1_rlast;
  logic [ADDR_W-1:0] s1_awaddr, s1_araddr;
  logic [7:0] s1_awlen, s1_arlen;
  logic [2:0] s1_awsize, s1_arsize;
  logic [ID_W-2:0] s1_awid, s1_arid, s1_bid, s1_rid;
  logic [DATA_W-1:0] s1_wdata, s1_rdata;
  logic [STRB_W-1:0] s1_wstrb;
  logic [1:0] s1_bresp, s1_rresp;
  logic m_awvalid, m_awready, m_awlock, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
  logic m_arvalid, m_arready, m_arlock, m_rvalid, m_rready, m_rlast;
  logic [ADDR_W-1:0] m_awaddr, m_araddr;
  logic [7:0] m_awlen, m_arlen;
  logic [2:0] m_awsize, m_arsize, m_awprot, m_arprot;
  logic [ID_W-1:0] m_awid, m_arid, m_bid, m_rid;
  logic [1:0] m_awburst, m_arburst, m_bresp, m_rresp;
  logic [3:0] m_awcache, m_arcache, m_awqos, m_arqos, m_awregion, m_arregion;
  logic [DATA_W-1:0] m_wdata, m_rdata;
  logic [STRB_W-1:0] m_wstrb;

  int checks = 0;
  int failures = 0;
  logic ar_last;  // side granted most recently (model)
  logic aw_last;

  ddr4_axi_arbiter_2to1 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .sys_clk(sys_clk), .sys_reset_n(sys_reset_n),
    .s0_awvalid(s0_awvalid), .s0_awready(s0_awready), .s0_awaddr(s0_awaddr), .s0_awlen(s0_awlen),
    .s0_awsize(s0_awsize), .s0_awid(s0_awid), .s0_wvalid(s0_wvalid), .s0_wready(s0_wready),
    .s0_wlast(s0_wlast), .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_bvalid(s0_bvalid),
    .s0_bready(s0_bready), .s0_bresp(s0_bresp), .s0_bid(s0_bid), .s0_arvalid(s0_arvalid),
    .s0_arready(s0_arready), .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arsize(s0_arsize),
    .s0_arid(s0_arid), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready), .s0_rlast(s0_rlast),
    .s0_rresp(s0_rresp), .s0_rdata(s0_rdata), .s0_rid(s0_rid),
    .s1_awvalid(s1_awvalid), .s1_awready(s1_awready), .s1_awaddr(s1_awaddr), .s1_awlen(s1_awlen),
    .s1_awsize(s1_awsize), .s1_awid(s1_awid), .s1_wvalid(s1_wvalid), .s1_wready(s1_wready),
    .s1_wlast(s1_wlast), .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_bvalid(s1_bvalid),
    .s1_bready(s1_bready), .s1_bresp(s1_bresp), .s1_bid(s1_bid), .s1_arvalid(s1_arvalid),
    .s1_arready(s1_arready), .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arsize(s1_arsize),
    .s1_arid(s1_arid), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready), .s1_rlast(s1_rlast),
    .s1_rresp(s1_rresp), .s1_rdata(s1_rdata), .s1_rid(s1_rid),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_awsize(m_awsize), .m_awid(m_awid), .m_awburst(m_awburst), .m_awlock(m_awlock),
    .m_awcache(m_awcache), .m_awprot(m_awprot), .m_awqos(m_awqos), .m_awregion(m_awregion),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wlast(m_wlast), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_bid(m_bid), .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arid(m_arid), .m_arburst(m_arburst),
    .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot), .m_arqos(m_arqos),
    .m_arregion(m_arregion), .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rlast(m_rlast),
    .m_rresp(m_rresp), .m_rdata(m_rdata), .m_rid(m_rid)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; outputs are read before the next one.
  task automatic tick();
    @(posedge sys_clk);
    #2;
  endtask

  // Reference arbitration: the sole requester wins; with two, the side not granted last wins.
  function automatic logic rr_pick(input logic [1:0] req, input logic last);
    if (req == 2'b11) return !last;
    return req[1];
  endfunction

  function automatic logic [ADDR_W-1:0] rnd_addr();
    return ADDR_W'({$urandom(), $urandom()});
  endfunction

  function automatic logic [ID_W-2:0] rnd_id();
    return (ID_W-1)'($urandom());
  endfunction

  function automatic logic [DATA_W-1:0] rnd_data();
    return {$urandom(), $urandom()};
  endfunction

  task automatic clear_inputs();
    {s0_awvalid, s0_wvalid, s0_wlast, s0_bready, s0_arvalid, s0_rready} = '0;
    {s1_awvalid, s1_wvalid, s1_wlast, s1_bready, s1_arvalid, s1_rready} = '0;
    {m_awready, m_wready, m_bvalid, m_arready, m_rvalid, m_rlast} = '0;
    s0_awaddr = '0; s0_awlen = '0; s0_awsize = '0; s0_awid = '0; s0_wdata = '0; s0_wstrb = '0;
    s0_araddr = '0; s0_arlen = '0; s0_arsize = '0; s0_arid = '0;
    s1_awaddr = '0; s1_awlen = '0; s1_awsize = '0; s1_awid = '0; s1_wdata = '0; s1_wstrb = '0;
    s1_araddr = '0; s1_arlen = '0; s1_arsize = '0; s1_arid = '0;
    m_bresp = '0; m_bid = '0; m_rresp = '0; m_rid = '0; m_rdata = '0;
  endtask

  task automatic do_reset();
    sys_reset_n = 1'b0;
    clear_inputs();
    repeat (2) tick();
    sys_reset_n = 1'b1;
    tick();
    ar_last = 1'b1;
    aw_last = 1'b1;
  endtask

  // Wait for an AR grant, check winner and forwarded request, then accept it after dly cycles.
  task automatic ar_round(input string tag, input int dly);
    int n;
    logic w;
    logic [1:0] req;
    logic [ID_W-2:0] eid;
    logic [ADDR_W-1:0] eaddr;
    n = 0;
    #1;
    while (!(s0_arready || s1_arready) && n < 8) begin
      tick();
      #1;
      n++;
    end
    chk({tag, "_grant_seen"}, 64'(n < 8), 64'd1);
    req = {s1_arvalid, s0_arvalid};
    w = rr_pick(req, ar_last);
    ar_last = w;
    chk({tag, "_s0_arready"}, 64'(s0_arready), 64'(!w));
    chk({tag, "_s1_arready"}, 64'(s1_arready), 64'(w));
    eid   = w ? s1_arid : s0_arid;
    eaddr = w ? s1_araddr : s0_araddr;
    tick();
    if (w) s1_arvalid = 1'b0;
    else   s0_arvalid = 1'b0;
    #1;
    chk({tag, "_m_arvalid"}, 64'(m_arvalid), 64'd1);
    chk({tag, "_m_arid"}, 64'(m_arid), 64'({w, eid}));
    chk({tag, "_m_araddr"}, 64'(m_araddr), 64'(eaddr));
    for (int d = 0; d < dly; d++) begin
      tick();
      #1;
      chk({tag, "_arvalid_hold"}, 64'(m_arvalid), 64'd1);
    end
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
  endtask

  initial begin
    logic [ID_W-2:0] id0, id2;
    logic [DATA_W-1:0] wd, rd;
    logic [ID_W-1:0] rid;
    logic [DATA_W-1:0] sent[$];
    logic [DATA_W-1:0] got[$];
    int idx;
    int cyc;

    // Reset behaviour with s0 requesting through reset.
    sys_reset_n = 1'b0;
    clear_inputs();
    ar_last = 1'b1;
    aw_last = 1'b1;
    s0_arvalid = 1'b1;
    s0_araddr  = rnd_addr();
    s0_arid    = rnd_id();
    id0 = s0_arid;
    repeat (3) tick();
    #1;
    chk("rst_m_arvalid", 64'(m_arvalid), 64'd0);
    chk("rst_s0_arready", 64'(s0_arready), 64'd0);
    chk("rst_m_awvalid", 64'(m_awvalid), 64'd0);
    sys_reset_n = 1'b1;
    #1;
    chk("rel_s0_arready_sync", 64'(s0_arready), 64'd0);
    tick();
    #1;
    chk("rel_s0_arready", 64'(s0_arready), 64'd1);
    chk("rel_m_arvalid_pre", 64'(m_arvalid), 64'd0);
    tick();
    s0_arvalid = 1'b0;
    #1;
    chk("rel_m_arvalid", 64'(m_arvalid), 64'd1);
    chk("rel_m_arid", 64'(m_arid), 64'({1'b0, id0}));
    chk("rel_m_arburst", 64'(m_arburst), 64'd1);
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
    #1;
    chk("rel_m_arvalid_done", 64'(m_arvalid), 64'd0);

    // Contention: both AR requesters held high, expect strict alternation from s0.
    do_reset();
    s0_arvalid = 1'b1; s0_araddr = rnd_addr(); s0_arid = rnd_id();
    s1_arvalid = 1'b1; s1_araddr = rnd_addr(); s1_arid = rnd_id();
    for (int i = 0; i < 4; i++) begin
      ar_round("contend", 0);
      chk("contend_order_msb", 64'(m_arid[ID_W-1]), 64'(i % 2));
      if (!s0_arvalid) begin s0_arvalid = 1'b1; s0_araddr = rnd_addr(); s0_arid = rnd_id(); end
      if (!s1_arvalid) begin s1_arvalid = 1'b1; s1_araddr = rnd_addr(); s1_arid = rnd_id(); end
    end
    s0_arvalid = 1'b0;
    s1_arvalid = 1'b0;
    tick();

    // Randomized AR traffic: random arrivals, pending requests stay asserted.
    for (int i = 0; i < 12; i++) begin
      if (!s0_arvalid && ($urandom_range(0, 1) == 1)) begin
        s0_arvalid = 1'b1; s0_araddr = rnd_addr(); s0_arid = rnd_id();
      end
      if (!s1_arvalid && ($urandom_range(0, 1) == 1)) begin
        s1_arvalid = 1'b1; s1_araddr = rnd_addr(); s1_arid = rnd_id();
      end
      if (!s0_arvalid && !s1_arvalid) begin
        s1_arvalid = 1'b1; s1_araddr = rnd_addr(); s1_arid = rnd_id();
      end
      ar_round("rand_ar", int'($urandom_range(0, 3)));
    end
    s0_arvalid = 1'b0;
    s1_arvalid = 1'b0;

    // Write from s1 with early W beats and a late AW accept; s0 waits behind it.
    do_reset();
    m_wready   = 1'b1;
    s1_awvalid = 1'b1; s1_awaddr = rnd_addr(); s1_awlen = 8'd3; s1_awsize = 3'd3; s1_awid = 15'h0005;
    #1;
    chk("wr_s1_awready", 64'(s1_awready), 64'(rr_pick(2'b10, aw_last)));
    aw_last = 1'b1;
    tick();
    s1_awvalid = 1'b0;
    s0_awvalid = 1'b1; s0_awaddr = rnd_addr(); s0_awlen = 8'd0; s0_awsize = 3'd3; s0_awid = rnd_id();
    id0 = s0_awid;
    for (int b = 0; b < 4; b++) begin
      wd = rnd_data();
      s1_wvalid = 1'b1; s1_wdata = wd; s1_wstrb = STRB_W'($urandom()); s1_wlast = (b == 3);
      #1;
      if (b == 0) begin
        chk("wr_m_awvalid", 64'(m_awvalid), 64'd1);
        chk("wr_m_awid", 64'(m_awid), 64'h8005);
        chk("wr_m_awlen", 64'(m_awlen), 64'd3);
      end
      chk("wr_m_wvalid", 64'(m_wvalid), 64'd1);
      chk("wr_m_wdata", m_wdata, wd);
      chk("wr_m_wlast", 64'(m_wlast), 64'(b == 3));
      chk("wr_s1_wready", 64'(s1_wready), 64'd1);
      chk("wr_s0_awready_blocked", 64'(s0_awready), 64'd0);
      tick();
    end
    s1_wvalid = 1'b0; s1_wlast = 1'b0;
    #1;
    chk("wr_m_wvalid_after_last", 64'(m_wvalid), 64'd0);
    chk("wr_s0_awready_aw_pending", 64'(s0_awready), 64'd0);
    tick();
    m_awready = 1'b1;
    #1;
    chk("wr_s0_awready_at_aw_hs", 64'(s0_awready), 64'd0);
    tick();
    m_awready = 1'b0;
    #1;
    chk("wr_s0_awready_granted", 64'(s0_awready), 64'(!rr_pick(2'b01, aw_last)));
    aw_last = 1'b0;
    tick();
    s0_awvalid = 1'b0;
    #1;
    chk("wr_s0_m_awid", 64'(m_awid), 64'({1'b0, id0}));

    // Same-cycle AW and wlast handshake, with a new s0 AW already waiting.
    wd = rnd_data();
    s0_wvalid = 1'b1; s0_wlast = 1'b1; s0_wdata = wd;
    m_awready = 1'b1;
    s0_awvalid = 1'b1; s0_awaddr = rnd_addr(); s0_awid = rnd_id();
    id2 = s0_awid;
    #1;
    chk("same_s0_wready", 64'(s0_wready), 64'd1);
    chk("same_m_wdata", m_wdata, wd);
    chk("same_s0_awready_busy", 64'(s0_awready), 64'd0);
    tick();
    s0_wvalid = 1'b0; s0_wlast = 1'b0; m_awready = 1'b0;
    #1;
    chk("same_s0_awready_idle", 64'(s0_awready), 64'd1);
    tick();
    s0_awvalid = 1'b0;
    #1;
    chk("same_m_awvalid", 64'(m_awvalid), 64'd1);
    chk("same_m_awid", 64'(m_awid), 64'({1'b0, id2}));
    m_awready = 1'b1;
    s0_wvalid = 1'b1; s0_wlast = 1'b1;
    tick();
    m_awready = 1'b0;
    s0_wvalid = 1'b0; s0_wlast = 1'b0;

    // Directed response routing.
    do_reset();
    rd = rnd_data();
    m_rvalid = 1'b1; m_rid = 16'h8003; m_rlast = 1'b1; m_rdata = rd;
    s1_rready = 1'b1; s0_rready = 1'b0;
    #1;
    chk("route_s1_rvalid", 64'(s1_rvalid), 64'd1);
    chk("route_s0_rvalid", 64'(s0_rvalid), 64'd0);
    chk("route_s1_rid", 64'(s1_rid), 64'h0003);
    chk("route_s1_rlast", 64'(s1_rlast), 64'd1);
    chk("route_s1_rdata", s1_rdata, rd);
    chk("route_m_rready_hi", 64'(m_rready), 64'd1);
    s1_rready = 1'b0;
    #1;
    chk("route_m_rready_lo", 64'(m_rready), 64'd0);
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    m_bvalid = 1'b1; m_bid = 16'h0007; m_bresp = 2'b10; s0_bready = 1'b1; s1_bready = 1'b0;
    #1;
    chk("route_s0_bvalid", 64'(s0_bvalid), 64'd1);
    chk("route_s1_bvalid", 64'(s1_bvalid), 64'd0);
    chk("route_s0_bid", 64'(s0_bid), 64'h0007);
    chk("route_s0_bresp", 64'(s0_bresp), 64'd2);
    chk("route_m_bready", 64'(m_bready), 64'd1);
    tick();
    m_bvalid = 1'b0;

    // Randomized routing of R beats by ID MSB.
    for (int i = 0; i < 10; i++) begin
      rid = ID_W'($urandom());
      rd  = rnd_data();
      m_rvalid = 1'b1; m_rid = rid; m_rdata = rd;
      s0_rready = 1'($urandom()); s1_rready = 1'($urandom());
      #1;
      chk("rr_s0_rvalid", 64'(s0_rvalid), 64'(!rid[ID_W-1]));
      chk("rr_s1_rvalid", 64'(s1_rvalid), 64'(rid[ID_W-1]));
      chk("rr_rid", 64'(rid[ID_W-1] ? s1_rid : s0_rid), 64'(rid % (1 << (ID_W-1))));
      chk("rr_m_rready", 64'(m_rready), 64'(rid[ID_W-1] ? s1_rready : s0_rready));
      tick();
    end
    m_rvalid = 1'b0;

    // Backpressure: 8-beat burst to s0 with a 10-cycle stall; every beat arrives once, in order.
    for (int i = 0; i < 8; i++) sent.push_back(rnd_data());
    idx = 0;
    cyc = 0;
    m_rid = {1'b0, rnd_id()};
    while (idx < 8 && cyc < 200) begin
      m_rvalid = 1'b1;
      m_rdata  = sent[idx];
      m_rlast  = (idx == 7);
      s0_rready = (cyc >= 3 && cyc < 13) ? 1'b0 : 1'($urandom());
      #1;
      if (cyc >= 3 && cyc < 13) chk("bp_m_rready_stalled", 64'(m_rready), 64'd0);
      if (s0_rvalid && s0_rready) got.push_back(s0_rdata);
      if (m_rvalid && m_rready) idx++;
      tick();
      cyc++;
    end
    m_rvalid = 1'b0; m_rlast = 1'b0; s0_rready = 1'b0;
    chk("bp_completed", 64'(idx), 64'd8);
    chk("bp_beat_count", 64'(got.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < got.size()) chk("bp_beat_data", got[i], sent[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
